// File: rtl/deletion_insert.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : deletion_insert                                                |
// | Brief   : Rebuilds an N-symbol quaternary codeword from an (N-1)-symbol  |
// |           word by inserting a located symbol, streaming it out with a    |
// |           valid/ready handshake and assembling a parallel copy.          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module deletion_insert #(
  parameter int N  = 100,
  parameter int IW = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*(N-1)-1:0]   word_in,
  input  logic [IW-1:0]        missing_index,
  input  logic [1:0]           missing_digit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [1:0]           sym_out,
  output logic [IW-1:0]        sym_idx,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic [2*N-1:0]       word_out,
  output logic                 word_valid,
  output logic                 idx_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] c_last = IW'(N - 1);
  localparam logic [IW-1:0] c_one  = IW'(1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_capture;
  logic                  w_accept;
  logic                  w_last;

  logic [2*(N-1)-1:0]    r_word;
  logic [IW-1:0]         r_pos;
  logic [1:0]            r_digit;
  logic [IW-1:0]         r_k;
  logic [1:0]            r_sym_out;
  logic                  r_sym_valid;
  logic                  r_in_ready;
  logic [2*N-1:0]        r_word_out;
  logic                  r_word_valid;
  logic                  r_idx_err;

  logic                  w_idx_bad;
  logic [IW-1:0]         w_pos_in;
  logic [IW-1:0]         w_k_next;
  logic [1:0]            w_sym_first;
  logic [1:0]            w_sym_succ;
  logic [IW:0]           w_bit_idx;

  // Codeword symbol k given the received word, insertion point and digit.
  function automatic logic [1:0] sym_at(
    input logic [2*(N-1)-1:0] w,
    input logic [IW-1:0]      pos,
    input logic [1:0]         d,
    input logic [IW-1:0]      k
  );
    if (k == pos) begin
      sym_at = d;
    end else if (k < pos) begin
      sym_at = 2'(w >> {k, 1'b0});
    end else begin
      sym_at = 2'(w >> {k - c_one, 1'b0});
    end
  endfunction

  // Out-of-range indices clamp to an append at the final position.
  assign w_idx_bad   = (missing_index > c_last);
  assign w_pos_in    = w_idx_bad ? c_last : missing_index;
  assign w_k_next    = r_k + c_one;
  assign w_sym_first = sym_at(word_in, w_pos_in, missing_digit, '0);
  assign w_sym_succ  = sym_at(r_word, r_pos, r_digit, w_k_next);
  assign w_bit_idx   = {r_k, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_capture    = 1'b1;
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        if (sym_ready) begin
          w_accept = 1'b1;
          if (r_k == c_last) begin
            w_last       = 1'b1;
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Flags are registered from the next state so every output comes off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= '0;
      r_pos        <= '0;
      r_digit      <= '0;
      r_k          <= '0;
      r_sym_out    <= '0;
      r_sym_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_idx_err    <= 1'b0;
    end else begin
      r_sym_valid  <= (w_state_next == S_FILL);
      r_word_valid <= (w_state_next == S_DONE);
      r_in_ready   <= (w_state_next == S_IDLE);
      if (w_capture) begin
        r_word     <= word_in;
        r_pos      <= w_pos_in;
        r_digit    <= missing_digit;
        r_idx_err  <= w_idx_bad;
        r_k        <= '0;
        r_sym_out  <= w_sym_first;
        r_word_out <= '0;
      end else if (w_accept) begin
        r_word_out[w_bit_idx +: 2] <= r_sym_out;
        if (!w_last) begin
          r_k       <= w_k_next;
          r_sym_out <= w_sym_succ;
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign sym_out    = r_sym_out;
  assign sym_idx    = r_k;
  assign sym_valid  = r_sym_valid;
  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign idx_err    = r_idx_err;

endmodule
`default_nettype wire

// File: tb/tb_deletion_insert.sv
`default_nettype none
// Testbench for deletion_insert: directed and random jobs checked against a
// queue-based insertion model.
module tb_deletion_insert;

  localparam int N  = 100;
  localparam int IW = 7;

  logic                 clk;
  logic                 rst_n;
  logic [2*(N-1)-1:0]   word_in;
  logic [IW-1:0]        missing_index;
  logic [1:0]           missing_digit;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           sym_out;
  logic [IW-1:0]        sym_idx;
  logic                 sym_valid;
  logic                 sym_ready;
  logic [2*N-1:0]       word_out;
  logic                 word_valid;
  logic                 idx_err;

  int n_pass;
  int n_fail;
  int n_total;

  deletion_insert #(.N(N), .IW(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .word_in       (word_in),
    .missing_index (missing_index),
    .missing_digit (missing_digit),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sym_out       (sym_out),
    .sym_idx       (sym_idx),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .idx_err       (idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list of received symbols with the digit spliced in.
  function automatic logic [2*N-1:0] ref_word(input logic [2*(N-1)-1:0] w, input int idx,
                                              input logic [1:0] d);
    logic [1:0] q[$];
    logic [2*N-1:0] r;
    int p;
    for (int i = 0; i < N-1; i++) q.push_back(w[2*i +: 2]);
    p = (idx >= N) ? N-1 : idx;
    q.insert(p, d);
    r = '0;
    for (int i = 0; i < N; i++) r[2*i +: 2] = q[i];
    return r;
  endfunction

  function automatic logic [2*(N-1)-1:0] rand_word();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[32*i +: 32] = $urandom;
    return r[2*(N-1)-1:0];
  endfunction

  // mode 0: sym_ready always 1; mode 1: sym_ready pattern 1,0,0,1 repeating.
  task automatic run_job(input logic [2*(N-1)-1:0] w, input int idx, input logic [1:0] d,
                         input int mode, input bit stray, input string tag);
    logic [2*N-1:0] exp_word;
    logic [2*N-1:0] got;
    logic [1:0]     prev_out;
    logic [IW-1:0]  prev_idx;
    bit             prev_stall;
    bit             rdy;
    int             acc, wv_c, last_acc_c, idx_gap, stall_bad, c;
    exp_word = ref_word(w, idx, d);
    got = '0;
    acc = 0; wv_c = -1; last_acc_c = -1; idx_gap = 0; stall_bad = 0;
    prev_stall = 0; prev_out = '0; prev_idx = '0;
    c = 0;
    while (!in_ready && c < 300) begin
      @(posedge clk); #1; c++;
    end
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    word_in = w; missing_index = IW'(idx); missing_digit = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (c = 1; c <= 800; c++) begin
      if (word_valid) begin
        wv_c = c;
        break;
      end
      if (sym_valid) begin
        if (prev_stall && (sym_out !== prev_out || sym_idx !== prev_idx)) stall_bad++;
        if (sym_idx !== IW'(acc)) idx_gap++;
        rdy = (mode == 0) ? 1'b1 : (((c-1) % 4 == 0) || ((c-1) % 4 == 3));
        sym_ready = rdy;
        if (rdy) begin
          if (acc < N) got[2*acc +: 2] = sym_out;
          acc++;
          last_acc_c = c;
        end
        prev_stall = !rdy; prev_out = sym_out; prev_idx = sym_idx;
      end else begin
        prev_stall = 0;
      end
      if (stray && acc < N-5) begin
        in_valid      = 1'($urandom);
        word_in       = rand_word();
        missing_index = IW'($urandom);
        missing_digit = 2'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    sym_ready = 1'b1;
    chk({tag, "_accepted"}, acc, N);
    chk({tag, "_stream"}, got, exp_word);
    chk({tag, "_idx_gaps"}, idx_gap, 0);
    chk({tag, "_stall_stable"}, stall_bad, 0);
    chk({tag, "_wv_cycle"}, wv_c, (mode == 0) ? N+1 : last_acc_c + 1);
    chk({tag, "_word_out"}, word_out, exp_word);
    chk({tag, "_idx_err"}, idx_err, (idx >= N) ? 1 : 0);
    chk({tag, "_sv_in_done"}, {sym_valid, in_ready}, 2'b00);
    @(posedge clk); #1;
    chk({tag, "_wv_one_cycle"}, word_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
    chk({tag, "_word_out_hold"}, word_out, exp_word);
  endtask

  logic [2*(N-1)-1:0] w_mod4;
  logic [2*(N-1)-1:0] w_tmp;
  int                 acc_r;
  int                 wv_seen;

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst_n = 1'b0; in_valid = 1'b0; sym_ready = 1'b1;
    word_in = '0; missing_index = '0; missing_digit = '0;
    for (int i = 0; i < N-1; i++) w_mod4[2*i +: 2] = 2'(i % 4);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {in_ready, sym_valid, sym_out, sym_idx, word_valid, idx_err},
        {1'b1, 1'b0, 2'b00, 7'd0, 1'b0, 1'b0});
    chk("rst_word_out", word_out, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);

    run_job({(N-1){2'b01}}, 0, 2'd3, 0, 0, "p0_ones");
    run_job(w_mod4, 99, 2'd2, 0, 0, "p99_mod4");
    run_job(w_mod4, 50, 2'd0, 0, 0, "p50_mod4");
    run_job(w_mod4, 50, 2'd0, 1, 0, "p50_toggle");
    run_job(rand_word(), 120, 2'd1, 0, 0, "idx120");
    run_job(rand_word(), 10, 2'($urandom), 0, 0, "idx10");
    for (int j = 0; j < 3; j++)
      run_job(rand_word(), int'($urandom_range(0, N-1)), 2'($urandom), j % 2, 0, "rand");
    run_job(rand_word(), int'($urandom_range(0, N-1)), 2'($urandom), 1, 1, "stray");

    // Abort a job with an asynchronous reset after 40 accepted symbols.
    w_tmp = rand_word();
    word_in = w_tmp; missing_index = 7'd30; missing_digit = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_r = 0;
    for (int c = 0; c < 200 && acc_r < 40; c++) begin
      if (sym_valid) acc_r++;
      @(posedge clk); #1;
    end
    chk("rst_mid_acc40", acc_r, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {in_ready, sym_valid, sym_out, sym_idx, word_valid, idx_err},
        {1'b1, 1'b0, 2'b00, 7'd0, 1'b0, 1'b0});
    chk("rst_mid_word_out", word_out, 0);
    wv_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (word_valid) wv_seen++;
    end
    chk("rst_mid_no_wv", wv_seen, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", in_ready, 1);
    run_job(rand_word(), int'($urandom_range(0, N-1)), 2'($urandom), 0, 0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
